// File: rtl/mac_window_feeder_pkg.sv
// Shared definitions for the MAC window feeder and the MAC side:
// FSM state encoding and patch/weight/pixel widths.
package mac_window_feeder_pkg;

    localparam int PATCH_W = 128;
    localparam int WGT_W   = 72;
    localparam int PIX_W   = 8;
    localparam int COL_W   = 4 * PIX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_STEP = 2'd2
    } state_t;

endpackage

// File: rtl/win_shift4.sv
// 4-column shift register holding the 4x4 int8 window.
// Ports: clk, rstn (async low), shift (load col at col 3, drop col 0),
//        col (32-bit column, byte r = row r), win (128-bit, byte row*4+col).
module win_shift4
    import mac_window_feeder_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               shift,
    input  logic [COL_W-1:0]   col,
    output logic [PATCH_W-1:0] win
);

    logic [COL_W-1:0] cols [4];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) cols[i] <= '0;
        end else if (shift) begin
            cols[0] <= cols[1];
            cols[1] <= cols[2];
            cols[2] <= cols[3];
            cols[3] <= col;
        end
    end

    // Column-major storage flattened to a row-major patch.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign win[(r*4+c)*PIX_W +: PIX_W] = cols[c][r*PIX_W +: PIX_W];
        end
    end

endmodule

// File: rtl/mac_window_feeder.sv
// Builds 4x4 int8 patches from streamed 4-pixel columns, sliding by 2 columns,
// and presents them with the latched 3x3 kernel to the MAC array.
// Ports: clk, rstn; i_start/i_weight (frame start, kernel);
//        s_vld/s_rdy/s_col (column stream); o_vld/o_din/o_weight (patch out);
//        o_busy (not idle); o_frame_done (with last patch of the frame).
module mac_window_feeder
    import mac_window_feeder_pkg::*;
#(
    parameter int IMG_W     = 16,
    parameter int NUM_STRIP = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_start,
    input  logic [WGT_W-1:0]   i_weight,
    input  logic               s_vld,
    output logic               s_rdy,
    input  logic [COL_W-1:0]   s_col,
    output logic               o_vld,
    output logic [PATCH_W-1:0] o_din,
    output logic [WGT_W-1:0]   o_weight,
    output logic               o_busy,
    output logic               o_frame_done
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int SW = $clog2(NUM_STRIP + 1);

    state_t           state, nxt;
    logic [CW-1:0]    col_cnt, col_n, col_inc;
    logic [SW-1:0]    strip_cnt, strip_n;
    logic [2:0]       fill_cnt, fill_n;
    logic [WGT_W-1:0] wgt_q, wgt_n;
    logic             vld_q, vld_n;
    logic             done_q, done_n;
    logic [PATCH_W-1:0] win, hold_q;
    logic             acc, last_col, strip_end;

    // The frame's final emit cycle is still S_STEP; no more columns then.
    assign s_rdy    = (state == S_FILL) || (state == S_STEP && !done_q);
    assign acc      = s_vld & s_rdy;
    assign col_inc  = col_cnt + 1'b1;
    assign last_col = (col_inc == CW'(IMG_W));

    win_shift4 u_win (
        .clk   (clk),
        .rstn  (rstn),
        .shift (acc),
        .col   (s_col),
        .win   (win)
    );

    always_comb begin
        nxt       = state;
        col_n     = col_cnt;
        strip_n   = strip_cnt;
        fill_n    = fill_cnt;
        wgt_n     = wgt_q;
        vld_n     = 1'b0;
        done_n    = 1'b0;
        strip_end = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_start) begin
                    nxt     = S_FILL;
                    wgt_n   = i_weight;
                    col_n   = '0;
                    strip_n = '0;
                    fill_n  = '0;
                end
            end
            S_FILL: begin
                if (acc) begin
                    col_n  = col_inc;
                    fill_n = fill_cnt + 3'd1;
                    if (fill_cnt == 3'd3) begin
                        vld_n     = 1'b1;
                        nxt       = S_STEP;
                        strip_end = last_col;
                    end
                end
            end
            S_STEP: begin
                if (done_q) begin
                    nxt = S_IDLE;
                end else if (acc) begin
                    col_n = col_inc;
                    // Odd count before increment: every 2nd column after fill.
                    if (col_cnt[0]) begin
                        vld_n     = 1'b1;
                        strip_end = last_col;
                    end
                end
            end
            default: nxt = S_IDLE;
        endcase
        if (strip_end) begin
            if (strip_cnt == SW'(NUM_STRIP - 1)) begin
                done_n = 1'b1;
            end else begin
                strip_n = strip_cnt + 1'b1;
                col_n   = '0;
                fill_n  = '0;
                nxt     = S_FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            col_cnt   <= '0;
            strip_cnt <= '0;
            fill_cnt  <= '0;
            wgt_q     <= '0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
            hold_q    <= '0;
        end else begin
            state     <= nxt;
            col_cnt   <= col_n;
            strip_cnt <= strip_n;
            fill_cnt  <= fill_n;
            wgt_q     <= wgt_n;
            vld_q     <= vld_n;
            done_q    <= done_n;
            if (vld_q) hold_q <= win;
        end
    end

    // Live window on the emit cycle, frozen copy until the next emit.
    assign o_din        = vld_q ? win : hold_q;
    assign o_vld        = vld_q;
    assign o_frame_done = done_q;
    assign o_weight     = wgt_q;
    assign o_busy       = (state != S_IDLE);

endmodule
